garbage_insert: RTL and testbench

Consumes the opponent's pending attack-line count and, on each piece lock, pushes that many garbage rows (full except one hole column) into the bottom of the local game board, shifting existing rows up. It sits directly downstream of the row-completion/send-line counter: its `delete` pulses decrement that counter one line at a time. It returns the rebuilt board to the board-storage logic through a one-cycle write strobe. It also flags top-out when occupied cells are pushed off the top.

---
 rtl/garbage_insert.sv | 142 ++++++++++++++
 tb/tb_garbage_insert.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/garbage_insert.sv
// Pushes up to MAX_INSERT garbage rows (one shared hole column) into the bottom of the board on a piece lock.
// board_we arrives N+1 cycles after the lock edge; pause stalls every register, and a lock while busy is dropped.
module garbage_insert #(
    parameter int BLOCKS_ROW = 10,
    parameter int BLOCKS_COL = 20,
    parameter int BITS_Y_POS = 5,
    parameter int MAX_INSERT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             state_rst,
    input  logic                             pause,
    input  logic                             lock,
    input  logic [BITS_Y_POS-1:0]            pending_lines,
    input  logic [BLOCKS_ROW*BLOCKS_COL-1:0] board_in,
    output logic [BLOCKS_ROW*BLOCKS_COL-1:0] board_out,
    output logic                             board_we,
    output logic                             delete,
    output logic                             busy,
    output logic                             topout
);

    localparam int BOARD_W = BLOCKS_ROW * BLOCKS_COL;
    localparam int HOLE_W  = $clog2(BLOCKS_ROW);
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [BITS_Y_POS-1:0] MAX_INS = BITS_Y_POS'(MAX_INSERT);
    localparam logic [BITS_Y_POS-1:0] ONE     = BITS_Y_POS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [BOARD_W-1:0]      r_work;
    logic [BOARD_W-1:0]      r_board_out;
    logic [BITS_Y_POS-1:0]   r_cnt;
    logic [HOLE_W-1:0]       r_hole;
    logic [7:0]              r_lfsr;
    logic                    r_board_we;
    logic                    r_delete;
    logic                    r_busy;
    logic                    r_topout;

    logic [7:0]              w_lfsr_next;
    logic [HOLE_W-1:0]       w_hole_now;
    logic [BITS_Y_POS-1:0]   w_n_ins;
    logic                    w_start;
    logic [BOARD_W-1:0]      w_shift_src;
    logic [HOLE_W-1:0]       w_shift_hole;
    logic [BLOCKS_ROW-1:0]   w_garbage;
    logic [BOARD_W-1:0]      w_shifted;
    logic                    w_top_lost;

    assign w_lfsr_next = (r_lfsr == 8'h00) ? LFSR_SEED
                       : {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_hole_now  = HOLE_W'(r_lfsr % BLOCKS_ROW);
    assign w_n_ins     = (pending_lines > MAX_INS) ? MAX_INS : pending_lines;
    // The IDLE busy-tail (board_we cycle just finished) still counts as busy for lock filtering.
    assign w_start     = (r_state == S_IDLE) && !r_busy && lock && (pending_lines != '0);

    // The first row is pushed on the lock edge itself, straight from board_in.
    assign w_shift_src  = (r_state == S_IDLE) ? board_in : r_work;
    assign w_shift_hole = (r_state == S_IDLE) ? w_hole_now : r_hole;
    assign w_garbage    = ~(BLOCKS_ROW'(1) << w_shift_hole);
    assign w_shifted    = {w_garbage, w_shift_src[BOARD_W-1:BLOCKS_ROW]};
    assign w_top_lost   = |w_shift_src[BLOCKS_ROW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_board_out <= '0;
            r_cnt       <= '0;
            r_hole      <= '0;
            r_lfsr      <= LFSR_SEED;
            r_board_we  <= 1'b0;
            r_delete    <= 1'b0;
            r_busy      <= 1'b0;
            r_topout    <= 1'b0;
        end else if (state_rst) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_board_out <= '0;
            r_cnt       <= '0;
            r_lfsr      <= LFSR_SEED;
            r_board_we  <= 1'b0;
            r_delete    <= 1'b0;
            r_busy      <= 1'b0;
            r_topout    <= 1'b0;
        end else if (pause) begin
            r_board_we  <= 1'b0;
            r_delete    <= 1'b0;
        end else begin
            r_lfsr      <= w_lfsr_next;
            r_board_we  <= 1'b0;
            r_delete    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (w_start) begin
                        r_work   <= w_shifted;
                        r_hole   <= w_hole_now;
                        r_cnt    <= w_n_ins - ONE;
                        r_delete <= 1'b1;
                        r_busy   <= 1'b1;
                        if (w_top_lost) begin
                            r_topout <= 1'b1;
                        end
                        r_state  <= (w_n_ins == ONE) ? S_WRITE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_work   <= w_shifted;
                    r_cnt    <= r_cnt - ONE;
                    r_delete <= 1'b1;
                    if (w_top_lost) begin
                        r_topout <= 1'b1;
                    end
                    if (r_cnt == ONE) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_board_out <= r_work;
                    r_board_we  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign board_out = r_board_out;
    assign board_we  = r_board_we;
    assign delete    = r_delete;
    assign busy      = r_busy;
    assign topout    = r_topout;

endmodule

// File: tb/tb_garbage_insert.sv
// Randomized and directed bench for garbage_insert against a transaction-level board model.
module tb_garbage_insert;

    localparam int RW = 10;
    localparam int CL = 20;
    localparam int BW = RW * CL;

    logic          clk = 1'b0;
    logic          rst;
    logic          state_rst;
    logic          pause;
    logic          lock;
    logic [4:0]    pending_lines;
    logic [BW-1:0] board_in;
    logic [BW-1:0] board_out;
    logic          board_we;
    logic          delete;
    logic          busy;
    logic          topout;

    always #5 clk = ~clk;

    garbage_insert #(
        .BLOCKS_ROW(RW), .BLOCKS_COL(CL), .BITS_Y_POS(5), .MAX_INSERT(4)
    ) dut (
        .clk(clk), .rst(rst), .state_rst(state_rst), .pause(pause), .lock(lock),
        .pending_lines(pending_lines), .board_in(board_in), .board_out(board_out),
        .board_we(board_we), .delete(delete), .busy(busy), .topout(topout)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: an accepted lock opens a window counted in unpaused edges (k=1 is the lock edge).
    logic [7:0]    m_lfsr;
    logic [BW-1:0] m_final;
    logic [BW-1:0] m_bout;
    bit            m_lost [1:4];
    bit            m_active, m_del, m_we, m_busy, m_top;
    int            m_k, m_n;

    int            cyc, del_cnt, we_cnt, we_at;
    logic [BW-1:0] last_board;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        if (s == 8'h00) return 8'hA5;
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic model_reset();
        m_lfsr = 8'hA5; m_active = 0; m_del = 0; m_we = 0; m_busy = 0; m_top = 0;
        m_bout = '0; m_k = 0; m_n = 0;
    endtask

    task automatic build_final(input int hole);
        logic [RW-1:0] rows [CL];
        for (int r = 0; r < CL; r++) rows[r] = board_in[r*RW +: RW];
        for (int i = 1; i <= m_n; i++) begin
            m_lost[i] = (rows[0] != '0);
            for (int r = 0; r < CL-1; r++) rows[r] = rows[r+1];
            rows[CL-1] = 10'h3FF & ~(10'd1 << hole);
        end
        for (int r = 0; r < CL; r++) m_final[r*RW +: RW] = rows[r];
    endtask

    task automatic model_step();
        int hole;
        if (state_rst) begin
            model_reset();
            return;
        end
        if (pause) begin
            m_del = 0; m_we = 0;
            return;
        end
        hole   = int'(m_lfsr) % RW;
        m_lfsr = lfsr_step(m_lfsr);
        m_del  = 0; m_we = 0;
        if (m_active) begin
            m_k++;
            if (m_k <= m_n) begin
                m_del = 1;
                if (m_lost[m_k]) m_top = 1;
            end else if (m_k == m_n + 1) begin
                m_we = 1; m_bout = m_final;
            end else begin
                m_active = 0; m_busy = 0;
            end
        end else if (lock && pending_lines != 0) begin
            m_n = (pending_lines > 4) ? 4 : int'(pending_lines);
            build_final(hole);
            m_active = 1; m_k = 1; m_del = 1; m_busy = 1;
            if (m_lost[1]) m_top = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("delete", delete, m_del);
        chk("board_we", board_we, m_we);
        chk("busy", busy, m_busy);
        chk("topout", topout, m_top);
        if (m_we) chk("board_out", board_out, m_bout);
        cyc++;
        if (delete) del_cnt++;
        if (board_we) begin
            we_cnt++; we_at = cyc; last_board = board_out;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mark();
        cyc = 0; del_cnt = 0; we_cnt = 0; we_at = -1; last_board = '0;
    endtask

    task automatic do_state_rst();
        state_rst = 1'b1; step(); state_rst = 1'b0;
    endtask

    function automatic logic [BW-1:0] rand_board(input int clear_top);
        logic [BW-1:0] b;
        for (int r = 0; r < CL; r++) b[r*RW +: RW] = (r < clear_top) ? 10'h0 : 10'($urandom);
        return b;
    endfunction

    logic [BW-1:0] exp_b;

    initial begin
        rst = 1'b0; state_rst = 1'b0; pause = 1'b0; lock = 1'b0;
        pending_lines = '0; board_in = '0;
        model_reset();
        mark();
        @(negedge clk); @(negedge clk);
        chk("rst_board_out", board_out, '0);
        chk("rst_board_we", board_we, 1'b0);
        chk("rst_delete", delete, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_topout", topout, 1'b0);
        chk("model_lfsr_a5", lfsr_step(8'hA5), 8'h4A);

        // Empty board, 2 rows, first edge after reset: hole = 0xA5 % 10 = 5.
        rst = 1'b1; lock = 1'b1; pending_lines = 5'd2; board_in = '0;
        mark(); step(); lock = 1'b0; run(5);
        exp_b = {10'h3DF, 10'h3DF, 180'h0};
        chk("t1_model_board", m_final, exp_b);
        chk("t1_board", last_board, exp_b);
        chk("t1_delete_cnt", del_cnt, 2);
        chk("t1_we_at", we_at, 3);
        chk("t1_topout", topout, 1'b0);

        // Oversized request is capped at four rows.
        lock = 1'b1; pending_lines = 5'd9; board_in = rand_board(4);
        mark(); step(); lock = 1'b0; run(7);
        chk("t2_delete_cnt", del_cnt, 4);
        chk("t2_we_cnt", we_cnt, 1);
        chk("t2_we_at", we_at, 5);

        // Top-out is sticky across a later lock and cleared by state_rst.
        do_state_rst();
        chk("t3_topout_clr0", topout, 1'b0);
        lock = 1'b1; pending_lines = 5'd1; board_in = 200'd1;
        mark(); step(); lock = 1'b0; run(3);
        chk("t3_topout_set", topout, 1'b1);
        lock = 1'b1; pending_lines = 5'd1; board_in = '0;
        step(); lock = 1'b0; run(3);
        chk("t3_topout_hold", topout, 1'b1);
        do_state_rst();
        chk("t3_topout_clr", topout, 1'b0);
        chk("t3_board_out_clr", board_out, '0);

        // Four-row insert, unpaused then with a 3-cycle pause; same LFSR phase both times.
        exp_b = {{4{10'h3DF}}, 10'h2AA, 150'h0};
        do_state_rst();
        lock = 1'b1; pending_lines = 5'd4; board_in = {10'h2AA, 190'h0};
        mark(); step(); lock = 1'b0; run(7);
        chk("t4_board", last_board, exp_b);
        chk("t4_we_at", we_at, 5);
        do_state_rst();
        lock = 1'b1; pending_lines = 5'd4; board_in = {10'h2AA, 190'h0};
        mark(); step(); lock = 1'b0; step();
        pause = 1'b1; run(3); pause = 1'b0; run(6);
        chk("t4p_board", last_board, exp_b);
        chk("t4p_delete_cnt", del_cnt, 4);
        chk("t4p_we_at", we_at, 8);

        // Ignored locks: zero pending, and a lock while busy.
        lock = 1'b1; pending_lines = 5'd0; board_in = rand_board(0);
        mark(); step(); lock = 1'b0; run(4);
        chk("t5_zero_delete", del_cnt, 0);
        chk("t5_zero_we", we_cnt, 0);
        lock = 1'b1; pending_lines = 5'd2; board_in = rand_board(2);
        mark(); step(); lock = 1'b0; step();
        lock = 1'b1; pending_lines = 5'd3; step(); lock = 1'b0; run(6);
        chk("t5_busy_delete", del_cnt, 2);
        chk("t5_busy_we", we_cnt, 1);
        chk("t5_busy_we_at", we_at, 3);

        // Async reset mid-shift, then the LFSR restarts from 0xA5.
        lock = 1'b1; pending_lines = 5'd4; board_in = '0;
        step(); lock = 1'b0; step();
        rst = 1'b0;
        #1;
        chk("t6_rst_delete", delete, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_we", board_we, 1'b0);
        chk("t6_rst_topout", topout, 1'b0);
        chk("t6_rst_board_out", board_out, '0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 1'b1; lock = 1'b1; pending_lines = 5'd1; board_in = '0;
        mark(); step(); lock = 1'b0; run(3);
        chk("t6_board", last_board, {10'h3DF, 190'h0});
        chk("t6_we_at", we_at, 2);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            lock          = ($urandom_range(0, 4) == 0);
            pending_lines = 5'($urandom_range(0, 9));
            pause         = ($urandom_range(0, 7) == 0);
            state_rst     = ($urandom_range(0, 149) == 0);
            board_in      = rand_board(int'($urandom_range(0, 8)));
            step();
        end
        lock = 1'b0; pause = 1'b0; state_rst = 1'b0;
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
